// File: rtl/frame_buf_pkg.sv
// Shared sizing constants for the ping-pong frame buffer.
package frame_buf_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 3;
  // One index bit selects between the two banks.
  localparam int BANK_W = 1;
endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one write port and one registered read port.
// The read register resets; the storage array does not.
module dp_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // rdata holds its value on cycles without a read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/frame_buf_pingpong.sv
// Ping-pong frame memory: the writer fills one bank while the reader drains
// the other; ownership swaps on accepted wr_done / rd_done pulses.
module frame_buf_pingpong
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_done,
  output logic                  wr_ready,
  output logic                  wr_bank,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_done,
  output logic                  rd_ready,
  output logic                  rd_bank,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  wr_overrun,
  output logic                  rd_underrun
);
  localparam int AW = ADDR_WIDTH + BANK_W;

  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       wr_acc, wr_done_acc, rd_acc, rd_done_acc;

  // Handshake: a strobe (wr_en/wr_done, rd_en/rd_done) is accepted on a rising
  // edge only when its side's ready is high in that cycle; ready depends on
  // registered state alone, and rejected strobes only raise the sticky flag.
  assign wr_ready    = ~full[wr_bank];
  assign rd_ready    = full[rd_bank];
  assign wr_acc      = wr_en & wr_ready;
  assign wr_done_acc = wr_done & wr_ready;
  assign rd_acc      = rd_en & rd_ready;
  assign rd_done_acc = rd_done & rd_ready;

  // Simultaneous completions never collide: both sides ready implies different banks.
  always_comb begin
    full_nxt = full;
    if (wr_done_acc) full_nxt[wr_bank] = 1'b1;
    if (rd_done_acc) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full        <= 2'b00;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      rd_valid    <= 1'b0;
      wr_overrun  <= 1'b0;
      rd_underrun <= 1'b0;
    end else begin
      full     <= full_nxt;
      rd_valid <= rd_acc;
      if (wr_done_acc) wr_bank <= ~wr_bank;
      if (rd_done_acc) rd_bank <= ~rd_bank;
      if ((wr_en | wr_done) & ~wr_ready) wr_overrun  <= 1'b1;
      if ((rd_en | rd_done) & ~rd_ready) rd_underrun <= 1'b1;
    end
  end

  dp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr ({wr_bank, wr_addr}),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr ({rd_bank, rd_addr}),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_frame_buf_pingpong.sv
// Directed bench for the ping-pong frame buffer with hand-computed expectations.
module tb_frame_buf_pingpong;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0, wr_done = 1'b0, rd_en = 1'b0, rd_done = 1'b0;
  logic [2:0]  wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ready, wr_bank, rd_ready, rd_bank, rd_valid, wr_overrun, rd_underrun;
  logic [15:0] rd_data;
  int n_checks = 0;
  int n_pass   = 0;

  frame_buf_pingpong #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .wr_ready(wr_ready), .wr_bank(wr_bank),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
    .rd_ready(rd_ready), .rd_bank(rd_bank), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_overrun(wr_overrun), .rd_underrun(rd_underrun)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic write_word(input logic [2:0] a, input logic [15:0] d, input logic done);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_done = done;
    tick();
    idle_inputs();
  endtask

  task automatic read_word(input logic [2:0] a, input logic done);
    rd_en = 1'b1; rd_addr = a; rd_done = done;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b exp 1", wr_ready); else n_pass++;
    n_checks++; if (rd_ready !== 1'b0) $display("FAIL reset_rd_ready got %b exp 0", rd_ready); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b exp 0", rd_valid); else n_pass++;
    n_checks++; if (rd_data !== 16'h0000) $display("FAIL reset_rd_data got %h exp 0000", rd_data); else n_pass++;
    n_checks++; if (wr_overrun !== 1'b0) $display("FAIL reset_wr_overrun got %b exp 0", wr_overrun); else n_pass++;
    n_checks++; if (rd_underrun !== 1'b0) $display("FAIL reset_rd_underrun got %b exp 0", rd_underrun); else n_pass++;
    n_checks++; if ({wr_bank, rd_bank} !== 2'b00) $display("FAIL reset_banks got %b exp 00", {wr_bank, rd_bank}); else n_pass++;
  endtask

  task automatic test_underrun();
    do_reset();
    rd_en = 1'b1; rd_done = 1'b1; rd_addr = 3'd1;
    tick();
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL underrun_rd_valid got %b exp 0", rd_valid); else n_pass++;
    n_checks++; if (rd_underrun !== 1'b1) $display("FAIL underrun_flag got %b exp 1", rd_underrun); else n_pass++;
    n_checks++; if (rd_bank !== 1'b0) $display("FAIL underrun_rd_bank got %b exp 0", rd_bank); else n_pass++;
    idle_inputs();
    tick();
    n_checks++; if (rd_underrun !== 1'b1) $display("FAIL underrun_sticky got %b exp 1", rd_underrun); else n_pass++;
    n_checks++; if (wr_overrun !== 1'b0) $display("FAIL underrun_wr_overrun got %b exp 0", wr_overrun); else n_pass++;
  endtask

  task automatic test_write_read();
    do_reset();
    for (int i = 0; i < 8; i++) write_word(3'(i), 16'(i + 1), i == 7);
    n_checks++; if (wr_bank !== 1'b1) $display("FAIL wrrd_wr_bank got %b exp 1", wr_bank); else n_pass++;
    n_checks++; if (rd_ready !== 1'b1) $display("FAIL wrrd_rd_ready got %b exp 1", rd_ready); else n_pass++;
    n_checks++; if (wr_ready !== 1'b1) $display("FAIL wrrd_wr_ready got %b exp 1", wr_ready); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      read_word(3'(i), 1'b0);
      n_checks++; if (rd_valid !== 1'b1) $display("FAIL wrrd_valid[%0d] got %b exp 1", i, rd_valid); else n_pass++;
      n_checks++; if (rd_data !== 16'(i + 1)) $display("FAIL wrrd_data[%0d] got %h exp %h", i, rd_data, 16'(i + 1)); else n_pass++;
    end
    tick();
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL wrrd_valid_drop got %b exp 0", rd_valid); else n_pass++;
    n_checks++; if (rd_data !== 16'h0008) $display("FAIL wrrd_data_hold got %h exp 0008", rd_data); else n_pass++;
  endtask

  // continues from test_write_read: bank 0 full, reader on bank 0, writer on bank 1
  task automatic test_overrun();
    for (int i = 0; i < 8; i++) write_word(3'(i), 16'h0100 + 16'(i), i == 7);
    n_checks++; if (wr_ready !== 1'b0) $display("FAIL ovr_wr_ready got %b exp 0", wr_ready); else n_pass++;
    n_checks++; if (wr_bank !== 1'b0) $display("FAIL ovr_wr_bank got %b exp 0", wr_bank); else n_pass++;
    n_checks++; if (wr_overrun !== 1'b0) $display("FAIL ovr_flag_before got %b exp 0", wr_overrun); else n_pass++;
    write_word(3'd2, 16'hBEEF, 1'b0);
    n_checks++; if (wr_overrun !== 1'b1) $display("FAIL ovr_flag got %b exp 1", wr_overrun); else n_pass++;
    read_word(3'd2, 1'b0);
    n_checks++; if (rd_data !== 16'h0003) $display("FAIL ovr_bank0_addr2 got %h exp 0003", rd_data); else n_pass++;
    read_word(3'd7, 1'b1);
    n_checks++; if (rd_data !== 16'h0008) $display("FAIL ovr_rd_with_done got %h exp 0008", rd_data); else n_pass++;
    n_checks++; if ({wr_bank, rd_bank, wr_ready, rd_ready} !== 4'b0111) $display("FAIL ovr_after_done got %b exp 0111", {wr_bank, rd_bank, wr_ready, rd_ready}); else n_pass++;
    read_word(3'd2, 1'b0);
    n_checks++; if (rd_data !== 16'h0102) $display("FAIL ovr_bank1_addr2 got %h exp 0102", rd_data); else n_pass++;
    n_checks++; if (wr_overrun !== 1'b1) $display("FAIL ovr_sticky got %b exp 1", wr_overrun); else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 8; i++) write_word(3'(i), 16'hA000 + 16'(i), i == 7);
    for (int i = 0; i < 7; i++) write_word(3'(i), 16'hB000 + 16'(i), 1'b0);
    // last write of bank 1 with wr_done, plus a read and rd_done on bank 0
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hB007; wr_done = 1'b1;
    rd_en = 1'b1; rd_addr = 3'd5; rd_done = 1'b1;
    tick();
    idle_inputs();
    n_checks++; if (rd_data !== 16'hA005) $display("FAIL sim_rd_data got %h exp a005", rd_data); else n_pass++;
    n_checks++; if ({wr_bank, rd_bank} !== 2'b01) $display("FAIL sim_banks got %b exp 01", {wr_bank, rd_bank}); else n_pass++;
    n_checks++; if ({wr_ready, rd_ready} !== 2'b11) $display("FAIL sim_ready got %b exp 11", {wr_ready, rd_ready}); else n_pass++;
    read_word(3'd7, 1'b0);
    n_checks++; if (rd_data !== 16'hB007) $display("FAIL sim_bank1_addr7 got %h exp b007", rd_data); else n_pass++;
    n_checks++; if ({wr_overrun, rd_underrun} !== 2'b00) $display("FAIL sim_flags got %b exp 00", {wr_overrun, rd_underrun}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_word(3'd4, 16'h5A5A, 1'b1);
    read_word(3'd4, 1'b0);
    n_checks++; if ({rd_valid, rd_data} !== {1'b1, 16'h5A5A}) $display("FAIL mid_pre got %b/%h exp 1/5a5a", rd_valid, rd_data); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL mid_rd_valid got %b exp 0", rd_valid); else n_pass++;
    n_checks++; if (rd_data !== 16'h0000) $display("FAIL mid_rd_data got %h exp 0000", rd_data); else n_pass++;
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if ({wr_ready, rd_ready} !== 2'b10) $display("FAIL mid_ready got %b exp 10", {wr_ready, rd_ready}); else n_pass++;
    n_checks++; if ({wr_bank, rd_bank} !== 2'b00) $display("FAIL mid_banks got %b exp 00", {wr_bank, rd_bank}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_underrun();
    test_write_read();
    test_overrun();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
